// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared definitions for the two-requester RAM arbiter: the
//               access FSM state encoding and the default RAM base address.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

  // Access sequencer states: sample in IDLE, drive the RAM in ACCESS,
  // report completion in RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Byte address of RAM word 0 unless overridden on the arbiter.
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two requester ports and the RAM port of the
//               arbiter.
//               slave  : seen by the arbiter (requests and RAM read data in,
//                        grants, completions and RAM controls out).
//               master : seen by the requesters / RAM model (mirror image).
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  // Requester side
  logic                  req0_i, req1_i;
  logic                  we0_i, we1_i;
  logic [DATA_WIDTH-1:0] addr0_i, addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i, wdata1_i;
  logic                  gnt0_o, gnt1_o;
  logic                  rvalid0_o, rvalid1_o;
  logic [DATA_WIDTH-1:0] rdata0_o, rdata1_o;
  logic                  err0_o, err1_o;

  // RAM side
  logic                  Write_Enable_o;
  logic [DATA_WIDTH-1:0] Address_o;
  logic [DATA_WIDTH-1:0] Write_Data_o;
  logic [DATA_WIDTH-1:0] Read_Data_i;

  modport slave (
    input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  Read_Data_i,
    output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o,
    output err0_o, err1_o,
    output Write_Enable_o, Address_o, Write_Data_o
  );

  modport master (
    output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output Read_Data_i,
    input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o,
    input  err0_o, err1_o,
    input  Write_Enable_o, Address_o, Write_Data_o
  );

endinterface
`default_nettype wire

// File: rtl/ram_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin decision. Returns a one-hot winner.
//   req   [1:0] : request vector (bit n = requester n)
//   last        : index of the requester granted most recently
//   grant [1:0] : one-hot winner, all-zero when nothing is requested
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // On a tie the requester that was not served last wins.
    if (req[0] && req[1]) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one single-port RAM between two requesters. Each
//               access takes a fixed three cycles (IDLE -> ACCESS -> RESP):
//               requests are sampled in IDLE, the winner is granted and the
//               RAM is driven in ACCESS, and the completion (read data or
//               address error) is reported in RESP.
//   clk   : clock, rising edge
//   reset : asynchronous reset, active low
//   bus   : requester and RAM signals (ram_arbiter_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(BASE_ADDR_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);

  // An address is legal when word aligned and inside the RAM window. The
  // window test divides the offset by four instead of multiplying the depth,
  // so the upper bound cannot overflow DATA_WIDTH.
  function automatic logic is_legal(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] offset;
    offset   = addr - BASE_ADDR;
    is_legal = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) &&
               ((offset >> 2) < DATA_WIDTH'(MEMORY_DEPTH));
  endfunction

  state_t                state;
  logic                  last_gnt;     // requester served most recently
  logic                  cur;          // requester owning the access in flight
  logic                  cur_we;
  logic                  cur_legal;
  logic                  gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_addr, ram_wdata;

  logic [1:0]            req_vec;
  logic [1:0]            win;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;
  logic [DATA_WIDTH-1:0] resp_data;

  assign req_vec = {bus.req1_i, bus.req0_i};

  rr_arbiter2 u_rr (
    .req   (req_vec),
    .last  (last_gnt),
    .grant (win)
  );

  assign sel_we    = win[1] ? bus.we1_i    : bus.we0_i;
  assign sel_addr  = win[1] ? bus.addr1_i  : bus.addr0_i;
  assign sel_wdata = win[1] ? bus.wdata1_i : bus.wdata0_i;

  // Writes and illegal accesses complete with zero data.
  assign resp_data = (cur_legal && !cur_we) ? bus.Read_Data_i : '0;

  // ram_addr / ram_wdata double as the latched address and write data of the
  // access in flight; they are loaded only on IDLE->ACCESS, so requester
  // inputs changing after the grant have no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cur       <= 1'b0;
      cur_we    <= 1'b0;
      cur_legal <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_vec) begin
            state     <= ACCESS;
            cur       <= win[1];
            last_gnt  <= win[1];
            cur_we    <= sel_we;
            cur_legal <= is_legal(sel_addr);
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            ram_we    <= sel_we && is_legal(sel_addr);
            gnt0      <= win[0];
            gnt1      <= win[1];
          end
        end
        ACCESS: begin
          state <= RESP;
          if (cur) begin
            rvalid1 <= 1'b1;
            err1    <= !cur_legal;
            rdata1  <= resp_data;
          end else begin
            rvalid0 <= 1'b1;
            err0    <= !cur_legal;
            rdata0  <= resp_data;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0_o         = gnt0;
  assign bus.gnt1_o         = gnt1;
  assign bus.rvalid0_o      = rvalid0;
  assign bus.rvalid1_o      = rvalid1;
  assign bus.err0_o         = err0;
  assign bus.err1_o         = err1;
  assign bus.rdata0_o       = rdata0;
  assign bus.rdata1_o       = rdata1;
  assign bus.Write_Enable_o = ram_we;
  assign bus.Address_o      = ram_addr;
  assign bus.Write_Data_o   = ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. A RAM model answers the
//               arbiter's RAM port; a transaction-level reference model
//               (expected memory image plus round-robin pointer) predicts the
//               grant order, per-cycle handshakes and completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int          DEPTH  = 64;
  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam longint      BASE_L = 64'h1001_0000;

  logic clk;
  logic reset;

  ram_arbiter_if #(.DATA_WIDTH(32)) bus ();

  ram_arbiter #(
    .MEMORY_DEPTH (DEPTH),
    .DATA_WIDTH   (32),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [31:0] exp_mem [DEPTH];
  int          last_gnt;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  function automatic bit model_legal(input logic [31:0] a);
    longint ua;
    ua = longint'({32'h0, a});
    return (a % 4 == 0) && (ua >= BASE_L) && (ua < BASE_L + 4 * DEPTH);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // ---------------- RAM model ----------------
  logic [31:0] ram [DEPTH];
  logic        ram_init = 1'b0;
  logic [31:0] ram_rd;
  logic [5:0]  ram_idx;
  logic        ram_hit;

  always_comb begin
    ram_hit = (bus.Address_o >= BASE) && (bus.Address_o < BASE + 32'(4 * DEPTH));
    ram_idx = 6'((bus.Address_o - BASE) >> 2);
    ram_rd  = 32'hDEAD_BEEF;
    if (ram_hit) ram_rd = ram[ram_idx];
  end
  assign bus.Read_Data_i = ram_rd;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (bus.Write_Enable_o && ram_hit) begin
      ram[ram_idx] <= bus.Write_Data_o;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return BASE + 32'(4 * DEPTH);
      1:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      2:       return BASE - 32'd4;
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  task automatic apply_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    last_gnt = 1;
  endtask

  // Issues up to one request per requester in an IDLE cycle and checks every
  // cycle until all of them have completed. Returns one cycle into IDLE.
  task automatic run_pair(input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                          input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    int          order[$];
    bit          w[2];
    logic [31:0] a[2];
    logic [31:0] d[2];
    bit          ex_we[2];
    bit          ex_err[2];
    logic [31:0] ex_rd[2];
    int          n, p;
    logic [4:0]  got, want;
    logic [32:0] rgot, rwant;
    w[0] = w0; a[0] = a0; d[0] = d0;
    w[1] = w1; a[1] = a1; d[1] = d1;
    if (v0 && v1) begin
      order.push_back(last_gnt == 0 ? 1 : 0);
      order.push_back(last_gnt == 0 ? 0 : 1);
    end else if (v0) begin
      order.push_back(0);
    end else if (v1) begin
      order.push_back(1);
    end
    n = order.size();
    if (n == 0) return;
    last_gnt = order[n-1];
    for (int k = 0; k < n; k++) begin
      p         = order[k];
      ex_err[k] = !model_legal(a[p]);
      ex_we[k]  = w[p] && !ex_err[k];
      ex_rd[k]  = 32'h0;
      if (!ex_err[k]) begin
        if (w[p]) exp_mem[model_idx(a[p])] = d[p];
        else      ex_rd[k] = exp_mem[model_idx(a[p])];
      end
    end
    bus.req0_i = v0; bus.we0_i = w0; bus.addr0_i = a0; bus.wdata0_i = d0;
    bus.req1_i = v1; bus.we1_i = w1; bus.addr1_i = a1; bus.wdata1_i = d1;
    for (int c = 1; c <= 3 * n - 1; c++) begin
      @(posedge clk); #1;
      want = '0;
      for (int k = 0; k < n; k++) begin
        if (c == 1 + 3 * k) begin
          want[4 - order[k]] = 1'b1;
          want[0]            = ex_we[k];
        end
        if (c == 2 + 3 * k) want[2 - order[k]] = 1'b1;
      end
      got = {bus.gnt0_o, bus.gnt1_o, bus.rvalid0_o, bus.rvalid1_o, bus.Write_Enable_o};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL handshake c%0d {gnt0,gnt1,rv0,rv1,we}: got %b expected %b", c, got, want);
      end
      for (int k = 0; k < n; k++) begin
        p = order[k];
        if (c == 1 + 3 * k) begin
          n_cmp++;
          if (bus.Address_o !== a[p]) begin
            n_bad++;
            $display("FAIL ram_addr port%0d: got %h expected %h", p, bus.Address_o, a[p]);
          end
          // Drop the request and scramble the inputs right after the grant.
          if (p == 0) begin
            bus.req0_i = 1'b0; bus.we0_i = 1'($urandom_range(0, 1));
            bus.addr0_i = $urandom; bus.wdata0_i = $urandom;
          end else begin
            bus.req1_i = 1'b0; bus.we1_i = 1'($urandom_range(0, 1));
            bus.addr1_i = $urandom; bus.wdata1_i = $urandom;
          end
        end
        if (c == 2 + 3 * k) begin
          rgot  = (p == 0) ? {bus.err0_o, bus.rdata0_o} : {bus.err1_o, bus.rdata1_o};
          rwant = {ex_err[k], ex_rd[k]};
          n_cmp++;
          if (rgot !== rwant) begin
            n_bad++;
            $display("FAIL response port%0d {err,rdata}: got %h expected %h", p, rgot, rwant);
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [6:0]   ctl;
    logic [127:0] dat;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ctl = {bus.gnt0_o, bus.gnt1_o, bus.rvalid0_o, bus.rvalid1_o, bus.err0_o, bus.err1_o, bus.Write_Enable_o};
    dat = {bus.Address_o, bus.Write_Data_o, bus.rdata0_o, bus.rdata1_o};
    n_cmp++;
    if (ctl !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b expected 0", ctl);
    end
    n_cmp++;
    if (dat !== 128'b0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0", dat);
    end
    reset    = 1'b1;
    last_gnt = 1;
  endtask

  task automatic test_single_write_read();
    run_pair(1'b1, 1'b1, BASE, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0);
    run_pair(1'b1, 1'b0, BASE, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_tie();
    apply_reset();
    run_pair(1'b1, 1'b1, BASE + 32'h8, 32'h1234_5678, 1'b1, 1'b1, BASE + 32'hC, 32'h9876_1234);
    run_pair(1'b1, 1'b0, BASE + 32'h8, 32'h0,         1'b1, 1'b0, BASE + 32'hC, 32'h0);
    run_pair(1'b1, 1'b0, BASE + 32'hC, 32'h0,         1'b1, 1'b0, BASE + 32'h8, 32'h0);
  endtask

  task automatic test_illegal();
    run_pair(1'b1, 1'b1, BASE + 32'h10,  32'hA0A0_A0A0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_pair(1'b1, 1'b1, BASE + 32'h100, 32'h5555_5555, 1'b1, 1'b1, BASE + 32'h2, 32'h6666_6666);
    run_pair(1'b1, 1'b0, BASE + 32'h100, 32'h0,         1'b1, 1'b0, BASE + 32'h2, 32'h0);
    run_pair(1'b1, 1'b1, BASE + 32'hFC,  32'h7777_0001, 1'b1, 1'b1, BASE - 32'h4, 32'h8888_0002);
    run_pair(1'b1, 1'b0, BASE + 32'hFC,  32'h0,         1'b1, 1'b0, BASE + 32'h10, 32'h0);
  endtask

  task automatic test_input_change();
    run_pair(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, BASE + 32'h20, 32'h1357_9BDF);
    run_pair(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, BASE + 32'h20, 32'h0);
  endtask

  task automatic test_reset_abort();
    logic [1:0]   gw;
    logic [6:0]   ctl;
    logic [127:0] dat;
    logic [2:0]   rv;
    run_pair(1'b1, 1'b1, BASE + 32'h14, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.req0_i = 1'b1; bus.we0_i = 1'b1;
    bus.addr0_i = BASE + 32'h14; bus.wdata0_i = 32'hABCD_EF12;
    @(posedge clk); #1;
    gw = {bus.gnt0_o, bus.Write_Enable_o};
    n_cmp++;
    if (gw !== 2'b11) begin
      n_bad++;
      $display("FAIL abort_access {gnt0,we}: got %b expected 11", gw);
    end
    #2;
    reset = 1'b0;
    #1;
    ctl = {bus.gnt0_o, bus.gnt1_o, bus.rvalid0_o, bus.rvalid1_o, bus.err0_o, bus.err1_o, bus.Write_Enable_o};
    dat = {bus.Address_o, bus.Write_Data_o, bus.rdata0_o, bus.rdata1_o};
    n_cmp++;
    if (ctl !== 7'b0) begin
      n_bad++;
      $display("FAIL abort_ctl: got %b expected 0", ctl);
    end
    n_cmp++;
    if (dat !== 128'b0) begin
      n_bad++;
      $display("FAIL abort_data: got %h expected 0", dat);
    end
    bus.req0_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        #2;
        reset    = 1'b1;
        last_gnt = 1;
      end
      rv = {bus.rvalid0_o, bus.rvalid1_o, bus.Write_Enable_o};
      n_cmp++;
      if (rv !== 3'b0) begin
        n_bad++;
        $display("FAIL abort_quiet c%0d {rv0,rv1,we}: got %b expected 0", i, rv);
      end
    end
    run_pair(1'b1, 1'b0, BASE + 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    bit v0, v1;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      run_pair(v0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
               v1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    last_gnt = 1;
    reset    = 1'b0;
    bus.req0_i = 1'b0; bus.we0_i = 1'b0; bus.addr0_i = 32'h0; bus.wdata0_i = 32'h0;
    bus.req1_i = 1'b0; bus.we1_i = 1'b0; bus.addr1_i = 32'h0; bus.wdata1_i = 32'h0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
    test_reset();
    test_single_write_read();
    test_tie();
    test_illegal();
    test_input_change();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
